vram_port_arbiter: RTL and testbench

- Shares one port of the 2048x9 video BSRAM between two requesters: the video scan-out fetcher (read-only, latency-critical) and the host (read/write).
- The RAM port runs in pipelined-output mode with synchronous reset. Read data appears READ_LATENCY cycles after the address and CE are registered at the pins.
- The block does fixed-priority arbitration with an anti-starvation override, registers the RAM pin signals, and routes each returned read word back to the requester that issued it.

---
 rtl/vram_port_arbiter_pkg.sv | 20 ++
 rtl/vram_port_arbiter_if.sv | 62 ++++++
 rtl/vram_port_arbiter_rsp_pipe.sv | 48 ++++
 rtl/vram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_port_arbiter_pkg.sv
// vram_arb_pkg
// Shared defaults and the requester tag encoding for the video RAM port
// arbiter. The tag travels alongside each issued access so that a returned
// read word can be routed back to whoever asked for it.
//
// Optional build macro used by the arbiter: VRAM_ARB_STATS_EN
package vram_arb_pkg;

   localparam int DEF_ADDR_W        = 11;  // 2048 words
   localparam int DEF_DATA_W        = 9;
   localparam int DEF_READ_LATENCY  = 2;   // pipelined-output BSRAM
   localparam int DEF_MAX_HOST_WAIT = 4;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VID  = 2'd1,
      TAG_HOST = 2'd2
   } req_tag_e;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if
// Bundles the two requester handshakes and the RAM pin signals.
//   slave  : arbiter side (takes requests, drives RAM pins and responses)
//   master : environment side (requesters plus the RAM model)
// With VRAM_ARB_STATS_EN defined the two statistics counters are carried too.
interface vram_port_arbiter_if
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              vid_req_valid;
   logic [ADDR_W-1:0] vid_req_addr;
   logic              vid_req_ready;
   logic              vid_rsp_valid;
   logic [DATA_W-1:0] vid_rsp_data;

   logic              host_req_valid;
   logic              host_req_we;
   logic [ADDR_W-1:0] host_req_addr;
   logic [DATA_W-1:0] host_req_wdata;
   logic              host_req_ready;
   logic              host_rsp_valid;
   logic [DATA_W-1:0] host_rsp_data;

   logic              ram_ce;
   logic              ram_wre;
   logic [ADDR_W+2:0] ram_ad;
   logic [DATA_W-1:0] ram_di;
   logic [DATA_W-1:0] ram_do;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0]       vid_stall_cnt;
   logic [15:0]       host_force_cnt;
`endif

   modport slave (
      input  vid_req_valid, vid_req_addr,
      input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
      input  ram_do,
      output vid_req_ready, vid_rsp_valid, vid_rsp_data,
      output host_req_ready, host_rsp_valid, host_rsp_data,
      output ram_ce, ram_wre, ram_ad, ram_di
`ifdef VRAM_ARB_STATS_EN
      , output vid_stall_cnt, host_force_cnt
`endif
   );

   modport master (
      output vid_req_valid, vid_req_addr,
      output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
      output ram_do,
      input  vid_req_ready, vid_rsp_valid, vid_rsp_data,
      input  host_req_ready, host_rsp_valid, host_rsp_data,
      input  ram_ce, ram_wre, ram_ad, ram_di
`ifdef VRAM_ARB_STATS_EN
      , input vid_stall_cnt, host_force_cnt
`endif
   );

endinterface

// File: rtl/vram_port_arbiter_rsp_pipe.sv
// vram_rsp_pipe
// Tag shift register that follows each issued access through the RAM
// pipeline, plus the demux that steers ram_do to the issuing requester.
// A tag entering at the accept edge reaches the last stage exactly when the
// RAM presents the matching word, so the response outputs are combinational
// from the last stage and ram_do.
//
// Ports
//   clk, reset_n      clock, async active-low reset (clears all tags)
//   issue_tag         tag of the access accepted this cycle (NONE if idle/write)
//   ram_do            RAM read data
//   vid_rsp_valid/_data, host_rsp_valid/_data   routed responses
module vram_rsp_pipe
   import vram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_READ_LATENCY + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  req_tag_e          issue_tag,
   input  logic [DATA_W-1:0] ram_do,
   output logic              vid_rsp_valid,
   output logic [DATA_W-1:0] vid_rsp_data,
   output logic              host_rsp_valid,
   output logic [DATA_W-1:0] host_rsp_data
);

   req_tag_e tag_q [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= TAG_NONE;
      end else begin
         tag_q[0] <= issue_tag;
         for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Data is forced to zero when not valid so idle/reset outputs stay quiet.
   always_comb begin
      vid_rsp_valid  = (tag_q[DEPTH-1] == TAG_VID);
      host_rsp_valid = (tag_q[DEPTH-1] == TAG_HOST);
      vid_rsp_data   = vid_rsp_valid  ? ram_do : '0;
      host_rsp_data  = host_rsp_valid ? ram_do : '0;
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
// Shares one pipelined-output BSRAM port between the video scan-out fetcher
// (read-only, wins ties) and the host (read/write). A host that has been
// stalled MAX_HOST_WAIT consecutive cycles is force-granted for one access.
// RAM pin signals are registered; returned reads are routed by vram_rsp_pipe.
//
// Ports
//   clk      single clock for the block and the RAM port
//   reset_n  async active-low reset
//   bus      vram_port_arbiter_if.slave: requester handshakes, responses,
//            RAM pins (ram_ce, ram_wre, ram_ad, ram_di, ram_do)
//
// Build option VRAM_ARB_STATS_EN adds vid_stall_cnt and host_force_cnt
// (16-bit saturating) on the interface; arbitration is unchanged.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int READ_LATENCY  = DEF_READ_LATENCY,
   parameter int MAX_HOST_WAIT = DEF_MAX_HOST_WAIT
) (
   input  logic          clk,
   input  logic          reset_n,
   vram_port_arbiter_if.slave bus
);

   localparam int WAIT_W = $clog2(MAX_HOST_WAIT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              force_host;
   logic              vid_ready;
   logic              host_ready;
   req_tag_e          issue_tag;

   logic              ram_ce_q;
   logic              ram_wre_q;
   logic [ADDR_W+2:0] ram_ad_q;
   logic [DATA_W-1:0] ram_di_q;

   logic              vid_rsp_valid;
   logic [DATA_W-1:0] vid_rsp_data;
   logic              host_rsp_valid;
   logic [DATA_W-1:0] host_rsp_data;

   assign force_host = (wait_cnt == WAIT_W'(MAX_HOST_WAIT));

   // Grant: readies only rise with their own valid, so each ready doubles as
   // the transfer strobe for that requester.
   always_comb begin
      host_ready = bus.host_req_valid && (!bus.vid_req_valid || force_host);
      vid_ready  = bus.vid_req_valid && !host_ready;
      issue_tag  = TAG_NONE;
      if (vid_ready)                          issue_tag = TAG_VID;
      else if (host_ready && !bus.host_req_we) issue_tag = TAG_HOST;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (bus.host_req_valid && !host_ready) begin
         if (!force_host) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Address/data hold on idle cycles; only CE and WRE drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_ce_q  <= 1'b0;
         ram_wre_q <= 1'b0;
         ram_ad_q  <= '0;
         ram_di_q  <= '0;
      end else begin
         ram_ce_q  <= vid_ready || host_ready;
         ram_wre_q <= host_ready && bus.host_req_we;
         if (host_ready) begin
            ram_ad_q <= {bus.host_req_addr, 3'b000};
            ram_di_q <= bus.host_req_wdata;
         end else if (vid_ready) begin
            ram_ad_q <= {bus.vid_req_addr, 3'b000};
         end
      end
   end

   vram_rsp_pipe #(
      .DATA_W (DATA_W),
      .DEPTH  (READ_LATENCY + 1)
   ) u_rsp_pipe (
      .clk            (clk),
      .reset_n        (reset_n),
      .issue_tag      (issue_tag),
      .ram_do         (bus.ram_do),
      .vid_rsp_valid  (vid_rsp_valid),
      .vid_rsp_data   (vid_rsp_data),
      .host_rsp_valid (host_rsp_valid),
      .host_rsp_data  (host_rsp_data)
   );

   assign bus.vid_req_ready  = vid_ready;
   assign bus.host_req_ready = host_ready;
   assign bus.vid_rsp_valid  = vid_rsp_valid;
   assign bus.vid_rsp_data   = vid_rsp_data;
   assign bus.host_rsp_valid = host_rsp_valid;
   assign bus.host_rsp_data  = host_rsp_data;
   assign bus.ram_ce         = ram_ce_q;
   assign bus.ram_wre        = ram_wre_q;
   assign bus.ram_ad         = ram_ad_q;
   assign bus.ram_di         = ram_di_q;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] vid_stall_cnt_q;
   logic [15:0] host_force_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vid_stall_cnt_q  <= '0;
         host_force_cnt_q <= '0;
      end else begin
         if (bus.vid_req_valid && !vid_ready && (vid_stall_cnt_q != 16'hFFFF))
            vid_stall_cnt_q <= vid_stall_cnt_q + 16'd1;
         if (host_ready && force_host && (host_force_cnt_q != 16'hFFFF))
            host_force_cnt_q <= host_force_cnt_q + 16'd1;
      end
   end

   assign bus.vid_stall_cnt  = vid_stall_cnt_q;
   assign bus.host_force_cnt = host_force_cnt_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference (grant rule,
// expected-response queues, reference memory image). A simple pipelined RAM
// model sits on the pins.
module tb_vram_port_arbiter;

   localparam int AW  = 11;
   localparam int DW  = 9;
   localparam int LAT = 3;   // accept -> rsp_valid
   localparam int MAXW = 4;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_port_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 5) return 9'h1A5;
      return DW'((i * 37 + 11) & 9'h1FF);
   endfunction

   // Pipelined-output RAM: address registered at the edge, data out two edges later.
   logic [DW-1:0] ram_mem [2048];
   logic [DW-1:0] rd1, rd2;
   logic          ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 2048; i++) ram_mem[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (bus.ram_ce) begin
         if (bus.ram_wre) ram_mem[bus.ram_ad[AW+2:3]] <= bus.ram_di;
         else             rd1 <= ram_mem[bus.ram_ad[AW+2:3]];
      end
      rd2 <= rd1;
   end
   assign bus.ram_do = rd2;

   // Reference state
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            wcnt = 0;
   logic [DW-1:0] ref_mem [2048];
   rsp_t          vq[$];
   rsp_t          hq[$];
   logic          p_ce, p_wre;
   logic [AW+2:0] p_ad;
   logic [DW-1:0] p_di;
   logic          acc_v, acc_h, obs_h;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_rsp(input string tag, inout rsp_t q[$], input logic v, input logic [DW-1:0] d);
      rsp_t r;
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         chk({tag, "_valid"}, v, 1);
         chk({tag, "_data"}, d, r.data);
      end else begin
         chk({tag, "_valid"}, v, 0);
      end
   endtask

   // One clock: check at the falling edge, advance the reference, step past the rising edge.
   task automatic cycle_chk();
      logic ev, eh;
      @(negedge clk);
      eh = bus.host_req_valid && (!bus.vid_req_valid || wcnt == MAXW);
      ev = bus.vid_req_valid && !eh;
      obs_h = bus.host_req_ready;
      chk("vid_req_ready", bus.vid_req_ready, ev);
      chk("host_req_ready", bus.host_req_ready, eh);
      chk("ram_ce", bus.ram_ce, p_ce);
      chk("ram_wre", bus.ram_wre, p_wre);
      if (p_ce) chk("ram_ad", bus.ram_ad, p_ad);
      if (p_wre) chk("ram_di", bus.ram_di, p_di);
      check_rsp("vid_rsp", vq, bus.vid_rsp_valid, bus.vid_rsp_data);
      check_rsp("host_rsp", hq, bus.host_rsp_valid, bus.host_rsp_data);

      p_ce  = ev || eh;
      p_wre = eh && bus.host_req_we;
      if (eh) begin
         p_ad = {bus.host_req_addr, 3'b000};
         if (bus.host_req_we) begin
            p_di = bus.host_req_wdata;
            ref_mem[bus.host_req_addr] = bus.host_req_wdata;
         end else begin
            hq.push_back(rsp_t'{cyc + LAT, ref_mem[bus.host_req_addr]});
         end
      end else if (ev) begin
         p_ad = {bus.vid_req_addr, 3'b000};
         vq.push_back(rsp_t'{cyc + LAT, ref_mem[bus.vid_req_addr]});
      end
      wcnt  = (bus.host_req_valid && !eh) ? ((wcnt < MAXW) ? wcnt + 1 : MAXW) : 0;
      acc_v = ev;
      acc_h = eh;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      bus.vid_req_valid  = 1'b0;
      bus.host_req_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle_chk();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ram_ce"}, bus.ram_ce, 0);
      chk({tag, "_ram_wre"}, bus.ram_wre, 0);
      chk({tag, "_ram_ad"}, bus.ram_ad, 0);
      chk({tag, "_ram_di"}, bus.ram_di, 0);
      chk({tag, "_vid_rsp_valid"}, bus.vid_rsp_valid, 0);
      chk({tag, "_host_rsp_valid"}, bus.host_rsp_valid, 0);
      chk({tag, "_vid_rsp_data"}, bus.vid_rsp_data, 0);
      chk({tag, "_host_rsp_data"}, bus.host_rsp_data, 0);
      chk({tag, "_vid_req_ready"}, bus.vid_req_ready, 0);
      chk({tag, "_host_req_ready"}, bus.host_req_ready, 0);
   endtask

   task automatic clear_model();
      vq.delete();
      hq.delete();
      wcnt = 0;
      p_ce = 1'b0; p_wre = 1'b0; p_ad = '0; p_di = '0;
   endtask

   initial begin
      int first_h;
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
      reset_n             = 1'b0;
      bus.vid_req_valid   = 1'b0;
      bus.vid_req_addr    = '0;
      bus.host_req_valid  = 1'b0;
      bus.host_req_we     = 1'b0;
      bus.host_req_addr   = '0;
      bus.host_req_wdata  = '0;
      clear_model();
      acc_v = 1'b0; acc_h = 1'b0; obs_h = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
`ifdef VRAM_ARB_STATS_EN
      chk("reset_vid_stall_cnt", bus.vid_stall_cnt, 0);
      chk("reset_host_force_cnt", bus.host_force_cnt, 0);
`endif
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // Video-only read of preloaded 0x005
      bus.vid_req_valid = 1'b1;
      bus.vid_req_addr  = 11'h005;
      cycle_chk();
      idle(5);

      // Contention: video holds valid 10 cycles, host read waits to be forced
      bus.vid_req_valid  = 1'b1;
      bus.vid_req_addr   = 11'h010;
      bus.host_req_valid = 1'b1;
      bus.host_req_we    = 1'b0;
      bus.host_req_addr  = 11'h020;
      first_h = -1;
      for (int k = 0; k < 10; k++) begin
         cycle_chk();
         if (obs_h && first_h < 0) first_h = k;
         if (acc_h) bus.host_req_valid = 1'b0;
      end
      chk("force_grant_cycle", first_h, 4);
      idle(5);
`ifdef VRAM_ARB_STATS_EN
      chk("host_force_cnt", bus.host_force_cnt, 1);
      chk("vid_stall_cnt", bus.vid_stall_cnt, 1);
`endif

      // Host write then read of the same address, back to back
      bus.host_req_valid = 1'b1;
      bus.host_req_we    = 1'b1;
      bus.host_req_addr  = 11'h7FF;
      bus.host_req_wdata = 9'h0C3;
      cycle_chk();
      bus.host_req_we    = 1'b0;
      cycle_chk();
      idle(5);

      // Interleaved streams
      for (int i = 0; i < 8; i++) begin
         bus.host_req_valid = 1'b0;
         bus.vid_req_valid  = 1'b1;
         bus.vid_req_addr   = AW'(i);
         cycle_chk();
         bus.vid_req_valid  = 1'b0;
         bus.host_req_valid = 1'b1;
         bus.host_req_we    = 1'b0;
         bus.host_req_addr  = AW'(11'h100 + i);
         cycle_chk();
      end
      idle(5);

      // Reset with two reads in flight
      bus.vid_req_valid = 1'b1;
      bus.vid_req_addr  = 11'h030;
      cycle_chk();
      bus.vid_req_addr  = 11'h031;
      cycle_chk();
      bus.vid_req_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midreset_vid_rsp_valid", bus.vid_rsp_valid, 0);
         @(posedge clk); #1;
         cyc++;
      end
      reset_n = 1'b1;
      clear_model();
      idle(4);
      bus.vid_req_valid = 1'b1;
      bus.vid_req_addr  = 11'h040;
      cycle_chk();
      idle(5);

      // Idle stretch
      idle(20);

      // Random traffic, requesters hold their request until accepted
      acc_v = 1'b0;
      acc_h = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!bus.vid_req_valid || acc_v) begin
            bus.vid_req_valid = ($urandom_range(0, 9) < 6);
            bus.vid_req_addr  = AW'($urandom_range(0, 31));
         end
         if (!bus.host_req_valid || acc_h) begin
            bus.host_req_valid = ($urandom_range(0, 9) < 5);
            bus.host_req_we    = 1'($urandom_range(0, 1));
            bus.host_req_addr  = AW'($urandom_range(0, 31));
            bus.host_req_wdata = DW'($urandom);
         end
         cycle_chk();
      end
      idle(6);
      chk("vid_queue_drained", vq.size(), 0);
      chk("host_queue_drained", hq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
